// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions: loader states, word geometry
// and the core opcodes used when inspecting loaded programs.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_DONE = 2'd1,
    ST_ERR  = 2'd2
  } ld_state_e;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [5:0] opcode_of(input logic [31:0] w);
    return w[31:26];
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte-to-word packer. The first byte of a word lands
// in [31:24]; a word closes on its 4th byte or on the last byte.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_i,
  input  logic        en_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic        word_wr_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] lane_word;

  // Merge incoming byte into its lane; lanes below stay zero,
  // which provides the zero-fill for a short final word.
  always_comb begin
    lane_word  = {byte_i, 24'h0} >> {byte_cnt_q, 3'b000};
    word_o     = asm_q | lane_word;
    word_wr_o  = en_i &&
                 (byte_cnt_q == 2'(BYTES_PER_WORD - 1) || last_i);
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    if (en_i) begin
      if (word_wr_o) begin
        byte_cnt_d = 2'd0;
        asm_d      = NOP_WORD;
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        asm_d      = word_o;
      end
    end
  end

  // Lane counter and partial-word register.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q <= 2'd0;
      asm_q      <= NOP_WORD;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: fills words from a byte stream,
// then releases the core and serves its fetches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_inst,
  output logic              fetch_valid,
  output logic              fetch_oob,
  output logic [ADDR_W-1:0] prog_len,
  output logic              load_done,
  output logic              cpu_start,
  output logic              err_overflow
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = IDX_W + 1;

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0] prog_len_q, prog_len_d;
  logic              cpu_start_q, cpu_start_d;
  logic              fvalid_q, fvalid_d;
  logic              foob_q, foob_d;
  logic [31:0]       finst_q, finst_d;
  logic [31:0]       mem_q [DEPTH];

  logic        accept;
  logic        full;
  logic        asm_en;
  logic [31:0] asm_word;
  logic        asm_wr;

  assign accept  = in_valid && (state_q == ST_LOAD);
  assign full    = (word_cnt_q == CNT_W'(DEPTH));
  assign asm_en  = accept && !full;
  assign cnt_inc = word_cnt_q + CNT_W'(1);

  imem_loader_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .byte_i    (in_byte),
    .en_i      (asm_en),
    .last_i    (in_last),
    .word_o    (asm_word),
    .word_wr_o (asm_wr)
  );

  // Load sequencing and DONE-state fetch response.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    prog_len_d  = prog_len_q;
    cpu_start_d = 1'b0;
    fvalid_d    = 1'b0;
    foob_d      = 1'b0;
    finst_d     = finst_q;
    unique case (state_q)
      ST_LOAD: begin
        if (accept && full) begin
          state_d    = ST_ERR;
          prog_len_d = ADDR_W'(DEPTH);
        end else if (asm_wr) begin
          word_cnt_d = cnt_inc;
          if (in_last) begin
            state_d     = ST_DONE;
            prog_len_d  = ADDR_W'(cnt_inc);
            cpu_start_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (fetch_en) begin
          fvalid_d = 1'b1;
          if (fetch_addr >= prog_len_q) begin
            foob_d  = 1'b1;
            finst_d = NOP_WORD;
          end else begin
            finst_d = mem_q[fetch_addr[IDX_W-1:0]];
          end
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  // Control and fetch-port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      word_cnt_q  <= '0;
      prog_len_q  <= '0;
      cpu_start_q <= 1'b0;
      fvalid_q    <= 1'b0;
      foob_q      <= 1'b0;
      finst_q     <= NOP_WORD;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      prog_len_q  <= prog_len_d;
      cpu_start_q <= cpu_start_d;
      fvalid_q    <= fvalid_d;
      foob_q      <= foob_d;
      finst_q     <= finst_d;
    end
  end

  // Instruction storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (asm_wr) begin
      mem_q[word_cnt_q[IDX_W-1:0]] <= asm_word;
    end
  end

  assign in_ready     = (state_q == ST_LOAD) && !reset;
  assign fetch_inst   = finst_q;
  assign fetch_valid  = fvalid_q;
  assign fetch_oob    = foob_q;
  assign prog_len     = prog_len_q;
  assign load_done    = (state_q == ST_DONE);
  assign cpu_start    = cpu_start_q;
  assign err_overflow = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed tables, corner
// sequences and randomized programs against a byte-list model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       fetch_inst;
  logic              fetch_valid;
  logic              fetch_oob;
  logic [ADDR_W-1:0] prog_len;
  logic              load_done;
  logic              cpu_start;
  logic              err_overflow;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .fetch_en     (fetch_en),
    .fetch_addr   (fetch_addr),
    .fetch_inst   (fetch_inst),
    .fetch_valid  (fetch_valid),
    .fetch_oob    (fetch_oob),
    .prog_len     (prog_len),
    .load_done    (load_done),
    .cpu_start    (cpu_start),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cpu_start) start_cnt <= start_cnt + 1;
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] inst;
    logic        oob;
  } fvec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    fetch_en = 1'b0;
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    start_cnt = 0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a, output logic [31:0] inst,
                       output logic v, output logic oob);
    fetch_en   = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    fetch_en = 1'b0;
    inst     = fetch_inst;
    v        = fetch_valid;
    oob      = fetch_oob;
  endtask

  // Word i of a program given as a byte list, big-endian, zero-filled.
  function automatic logic [31:0] model_word(ref logic [7:0] q[$],
                                             input int i);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (4 * i + k < q.size())
        w = w | (32'(q[4 * i + k]) << (24 - 8 * k));
    end
    return w;
  endfunction

  task automatic fcheck(input string name, input logic [7:0] a,
                        input logic [31:0] ei, input logic eo);
    logic [31:0] inst;
    logic        v, oob;
    fetch(a, inst, v, oob);
    check({name, "_valid"}, 32'(v), 32'd1);
    check({name, "_inst"}, inst, ei);
    check({name, "_oob"}, 32'(oob), 32'(eo));
  endtask

  fvec_t vt[5];

  initial begin
    logic [7:0]  prog[$];
    logic [31:0] inst, exp_w;
    logic        v, oob;
    int          n, nw;

    reset      = 1'b1;
    in_byte    = 8'h0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    fetch_en   = 1'b0;
    fetch_addr = '0;

    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_prog_len", 32'(prog_len), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    check("rst_fvalid", 32'(fetch_valid), 32'd0);
    check("rst_finst", fetch_inst, 32'd0);
    check("rst_foob", 32'(fetch_oob), 32'd0);

    // Fetch during LOAD is ignored.
    fetch(8'd0, inst, v, oob);
    check("load_fetch_valid", 32'(v), 32'd0);

    // Two-word program.
    prog = '{8'h8C, 8'h20, 8'h00, 8'h00, 8'h8C, 8'h40, 8'h00, 8'h01};
    foreach (prog[i]) send_byte(prog[i], i == prog.size() - 1);
    check("two_load_done", 32'(load_done), 32'd1);
    check("two_start_now", 32'(cpu_start), 32'd1);
    idle(3);
    check("two_start_cnt", 32'(start_cnt), 32'd1);
    check("two_prog_len", 32'(prog_len), 32'd2);
    check("two_in_ready", 32'(in_ready), 32'd0);

    vt[0] = '{addr: 8'd0, inst: 32'h8C200000, oob: 1'b0};
    vt[1] = '{addr: 8'd1, inst: 32'h8C400001, oob: 1'b0};
    vt[2] = '{addr: 8'd2, inst: 32'h0, oob: 1'b1};
    vt[3] = '{addr: 8'd5, inst: 32'h0, oob: 1'b1};
    vt[4] = '{addr: 8'd255, inst: 32'h0, oob: 1'b1};
    foreach (vt[i]) fcheck($sformatf("tab%0d", i), vt[i].addr,
                           vt[i].inst, vt[i].oob);

    fetch(8'd0, inst, v, oob);
    check("opcode_lw", 32'(opcode_of(inst)), 32'(OP_LW));

    // Back-to-back fetches.
    fetch_en   = 1'b1;
    fetch_addr = 8'd1;
    @(negedge clk);
    check("b2b0_valid", 32'(fetch_valid), 32'd1);
    check("b2b0_inst", fetch_inst, 32'h8C400001);
    fetch_addr = 8'd0;
    @(negedge clk);
    fetch_en = 1'b0;
    check("b2b1_valid", 32'(fetch_valid), 32'd1);
    check("b2b1_inst", fetch_inst, 32'h8C200000);
    @(negedge clk);
    check("b2b_end_valid", 32'(fetch_valid), 32'd0);

    // Bytes during DONE are ignored.
    send_byte(8'hFF, 1'b0);
    send_byte(8'hEE, 1'b1);
    idle(2);
    check("done_ign_len", 32'(prog_len), 32'd2);
    check("done_ign_start", 32'(start_cnt), 32'd1);
    fcheck("done_ign_m0", 8'd0, 32'h8C200000, 1'b0);

    // Partial final word.
    do_reset();
    send_byte(8'h24, 1'b0);
    send_byte(8'h80, 1'b1);
    idle(1);
    check("part_done", 32'(load_done), 32'd1);
    check("part_len", 32'(prog_len), 32'd1);
    fcheck("part_m0", 8'd0, 32'h24800000, 1'b0);

    // Overflow after DEPTH full words.
    do_reset();
    for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'(i), 1'b0);
    check("ovf_pre_ready", 32'(in_ready), 32'd1);
    send_byte(8'hAA, 1'b0);
    idle(2);
    check("ovf_err", 32'(err_overflow), 32'd1);
    check("ovf_ready", 32'(in_ready), 32'd0);
    check("ovf_done", 32'(load_done), 32'd0);
    check("ovf_start", 32'(start_cnt), 32'd0);
    check("ovf_len", 32'(prog_len), 32'(DEPTH));
    fetch(8'd0, inst, v, oob);
    check("ovf_fetch_valid", 32'(v), 32'd0);

    // Exactly DEPTH words ending with in_last.
    do_reset();
    for (int i = 0; i < 4 * DEPTH; i++)
      send_byte(8'(i + 1), i == 4 * DEPTH - 1);
    idle(1);
    check("full_done", 32'(load_done), 32'd1);
    check("full_err", 32'(err_overflow), 32'd0);
    check("full_len", 32'(prog_len), 32'(DEPTH));
    fcheck("full_last", 8'(DEPTH - 1), 32'h3D3E3F40, 1'b0);

    // Reset mid-word restarts alignment.
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'hF0 + 8'(i), 1'b0);
    do_reset();
    check("mid_len", 32'(prog_len), 32'd0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b1);
    idle(1);
    check("mid_new_len", 32'(prog_len), 32'd1);
    fcheck("mid_m0", 8'd0, 32'h20010005, 1'b0);
    fcheck("mid_m1", 8'd1, 32'h0, 1'b1);

    // Randomized programs with idle gaps.
    for (int t = 0; t < 20; t++) begin
      do_reset();
      n = $urandom_range(1, 4 * DEPTH);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
      foreach (prog[i]) begin
        idle($urandom_range(0, 2));
        send_byte(prog[i], i == n - 1);
      end
      nw = (n + 3) / 4;
      idle(1);
      check($sformatf("rnd%0d_len", t), 32'(prog_len), 32'(nw));
      check($sformatf("rnd%0d_start", t), 32'(start_cnt), 32'd1);
      for (int k = 0; k < 6; k++) begin
        int a;
        a = $urandom_range(0, DEPTH + 4);
        exp_w = (a < nw) ? model_word(prog, a) : 32'h0;
        fcheck($sformatf("rnd%0d_f%0d", t, a), 8'(a), exp_w,
               a >= nw);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
